// File: rtl/axis_conv_in_slice_pkg.sv
// Shared parameters and types for the conv-engine input slice.
// Holds the conv tuser bit indices, the bus geometry and the derived
// pixel/weight widths, the packed beat payload type and the skid-register
// state encoding.
package axis_conv_in_slice_pkg;

    // Bus geometry
    localparam int UNITS               = 8;
    localparam int COPIES              = 2;
    localparam int CORES               = 4;
    localparam int MEMBERS             = 8;
    localparam int WORD_WIDTH          = 8;

    // Conv tuser layout
    localparam int TUSER_WIDTH_CONV_IN = 16;
    localparam int I_IS_CONFIG         = 6;

    // Derived widths
    localparam int PIXELS_WIDTH        = COPIES * WORD_WIDTH * UNITS;
    localparam int WEIGHTS_WIDTH       = WORD_WIDTH * CORES * MEMBERS;

    // One beat moves through the slice as a single vector.
    typedef struct packed {
        logic                           tlast;
        logic [TUSER_WIDTH_CONV_IN-1:0] tuser;
        logic [PIXELS_WIDTH-1:0]        pixels;
        logic [WEIGHTS_WIDTH-1:0]       weights;
    } conv_in_beat_t;

    // EMPTY: main invalid; ONE: main valid; FULL: main and skid valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/axis_conv_in_slice_if.sv
// AXI-Stream bundle carrying synchronised pixels, weights and conv tuser.
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both high; the master holds tvalid and payload stable until then.
// Modports: master drives tvalid/tlast/tuser/pixels/weights and samples
// tready; slave is the mirror image.
interface axis_conv_in_slice_if;
    import axis_conv_in_slice_pkg::*;

    logic                           tvalid;
    logic                           tready;
    logic                           tlast;
    logic [TUSER_WIDTH_CONV_IN-1:0] tuser;
    logic [PIXELS_WIDTH-1:0]        pixels_tdata;
    logic [WEIGHTS_WIDTH-1:0]       weights_tdata;

    modport master (
        output tvalid, tlast, tuser, pixels_tdata, weights_tdata,
        input  tready
    );

    modport slave (
        input  tvalid, tlast, tuser, pixels_tdata, weights_tdata,
        output tready
    );

endinterface

// File: rtl/axis_conv_in_slice_skid_reg.sv
// Generic 2-entry skid register (width W), full throughput, 1-cycle latency.
// s_ready and m_valid are flops, so neither side's ready/valid reaches the
// other combinationally. state exposes the occupancy FSM for debug.
// Ports: clk/rst (sync, active high), s_valid/s_ready/s_data in,
//        m_valid/m_ready/m_data out, state (debug).
module axis_conv_in_slice_skid_reg
    import axis_conv_in_slice_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output skid_state_e  state
);

    skid_state_e  state_q, state_d;
    logic         ready_q, ready_d;
    logic         valid_q, valid_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_hs, out_hs;

    always_comb begin
        in_hs   = s_valid && ready_q;
        out_hs  = valid_q && m_ready;
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_hs) begin
                    main_d  = s_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_hs && out_hs) begin
                    main_d = s_data;
                end else if (in_hs) begin
                    // Downstream stalled: park the new beat behind main.
                    skid_d  = s_data;
                    state_d = ST_FULL;
                end else if (out_hs) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // s_ready is low here, so only the drain can happen.
                if (out_hs) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Outputs are decoded from the next state and registered.
        ready_d = (state_d != ST_FULL);
        valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    // Payload registers need no reset; they are qualified by valid_q.
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign s_ready = ready_q;
    assign m_valid = valid_q;
    assign m_data  = main_q;
    assign state   = state_q;

endmodule

// File: rtl/axis_conv_in_slice.sv
// Registered AXI-Stream slice between the input pipe and the conv engine.
// Wraps a 2-entry skid register around the {tlast, tuser, pixels, weights}
// payload and adds per-packet beat/config/packet counters plus sticky
// protocol-error flags. Counters advance on the output handshake only.
// Ports: aclk, areset (sync, active high); s_axis (slave) in; m_axis
//        (master) out; stat_* counters; err_* sticky flags; dbg_state.
module axis_conv_in_slice
    import axis_conv_in_slice_pkg::*;
#(
    parameter int BEATS_WIDTH   = 20,
    parameter int PACKETS_WIDTH = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    axis_conv_in_slice_if.slave      s_axis,
    axis_conv_in_slice_if.master     m_axis,
    output logic [BEATS_WIDTH-1:0]   stat_beats,
    output logic [BEATS_WIDTH-1:0]   stat_last_beats,
    output logic [BEATS_WIDTH-1:0]   stat_config_beats,
    output logic [PACKETS_WIDTH-1:0] stat_packets,
    output logic                     err_valid_drop,
    output logic                     err_beat_ovf,
    output skid_state_e              dbg_state
);

    localparam int                     W         = $bits(conv_in_beat_t);
    localparam logic [BEATS_WIDTH-1:0] BEATS_MAX = '1;

    conv_in_beat_t  in_beat, out_beat;
    logic [W-1:0]   out_vec;
    logic           s_ready, m_valid, out_hs;

    assign in_beat = '{tlast:   s_axis.tlast,
                       tuser:   s_axis.tuser,
                       pixels:  s_axis.pixels_tdata,
                       weights: s_axis.weights_tdata};

    axis_conv_in_slice_skid_reg #(.W(W)) u_skid (
        .clk     (aclk),
        .rst     (areset),
        .s_valid (s_axis.tvalid),
        .s_ready (s_ready),
        .s_data  (in_beat),
        .m_valid (m_valid),
        .m_ready (m_axis.tready),
        .m_data  (out_vec),
        .state   (dbg_state)
    );

    assign out_beat             = conv_in_beat_t'(out_vec);
    assign s_axis.tready        = s_ready;
    assign m_axis.tvalid        = m_valid;
    assign m_axis.tlast         = out_beat.tlast;
    assign m_axis.tuser         = out_beat.tuser;
    assign m_axis.pixels_tdata  = out_beat.pixels;
    assign m_axis.weights_tdata = out_beat.weights;
    assign out_hs               = m_valid && m_axis.tready;

    logic [BEATS_WIDTH-1:0]   beats_q, beats_d;
    logic [BEATS_WIDTH-1:0]   cfg_q, cfg_d;
    logic [BEATS_WIDTH-1:0]   last_beats_q, last_beats_d;
    logic [BEATS_WIDTH-1:0]   config_beats_q, config_beats_d;
    logic [PACKETS_WIDTH-1:0] packets_q, packets_d;
    logic                     stall_q, stall_d;
    logic                     drop_q, drop_d;
    logic                     ovf_q, ovf_d;
    logic [BEATS_WIDTH-1:0]   beats_inc, cfg_inc, cfg_next;

    always_comb begin
        beats_inc      = (beats_q == BEATS_MAX) ? beats_q : beats_q + 1'b1;
        cfg_inc        = (cfg_q == BEATS_MAX) ? cfg_q : cfg_q + 1'b1;
        cfg_next       = out_beat.tuser[I_IS_CONFIG] ? cfg_inc : cfg_q;
        beats_d        = beats_q;
        cfg_d          = cfg_q;
        last_beats_d   = last_beats_q;
        config_beats_d = config_beats_q;
        packets_d      = packets_q;
        ovf_d          = ovf_q;
        // Upstream offered a beat that was refused last cycle and has now
        // withdrawn it without a transfer.
        stall_d        = s_axis.tvalid && !s_ready;
        drop_d         = drop_q || (stall_q && !s_axis.tvalid);
        if (out_hs) begin
            if (out_beat.tlast) begin
                last_beats_d   = beats_inc;
                config_beats_d = cfg_next;
                beats_d        = '0;
                cfg_d          = '0;
                packets_d      = packets_q + 1'b1;
            end else begin
                beats_d = beats_inc;
                cfg_d   = cfg_next;
                if (beats_inc == BEATS_MAX) begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            beats_q        <= '0;
            cfg_q          <= '0;
            last_beats_q   <= '0;
            config_beats_q <= '0;
            packets_q      <= '0;
            stall_q        <= 1'b0;
            drop_q         <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            beats_q        <= beats_d;
            cfg_q          <= cfg_d;
            last_beats_q   <= last_beats_d;
            config_beats_q <= config_beats_d;
            packets_q      <= packets_d;
            stall_q        <= stall_d;
            drop_q         <= drop_d;
            ovf_q          <= ovf_d;
        end
    end

    assign stat_beats        = beats_q;
    assign stat_last_beats   = last_beats_q;
    assign stat_config_beats = config_beats_q;
    assign stat_packets      = packets_q;
    assign err_valid_drop    = drop_q;
    assign err_beat_ovf      = ovf_q;

endmodule

// File: tb/tb_axis_conv_in_slice.sv
// Bench for axis_conv_in_slice: a wide-counter DUT plus a BEATS_WIDTH=3 DUT
// sharing the same stimulus. A monitor keeps an occupancy model and an
// expected-beat queue; packet tests come from a vector table, corner cases
// are hand-written sequences.
module tb_axis_conv_in_slice;
    import axis_conv_in_slice_pkg::*;

    localparam int W = $bits(conv_in_beat_t);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_conv_in_slice_if s_if();
    axis_conv_in_slice_if m_if();
    axis_conv_in_slice_if s2_if();
    axis_conv_in_slice_if m2_if();

    assign s2_if.tvalid        = s_if.tvalid;
    assign s2_if.tlast         = s_if.tlast;
    assign s2_if.tuser         = s_if.tuser;
    assign s2_if.pixels_tdata  = s_if.pixels_tdata;
    assign s2_if.weights_tdata = s_if.weights_tdata;
    assign m2_if.tready        = m_if.tready;

    logic [19:0] stat_beats, stat_last_beats, stat_config_beats;
    logic [15:0] stat_packets;
    logic        err_valid_drop, err_beat_ovf;
    skid_state_e dbg_state;
    logic [2:0]  stat_beats2, stat_last_beats2, stat_config_beats2;
    logic [15:0] stat_packets2;
    logic        err_valid_drop2, err_beat_ovf2;
    skid_state_e dbg_state2;

    axis_conv_in_slice #(.BEATS_WIDTH(20), .PACKETS_WIDTH(16)) dut (
        .aclk(clk), .areset(rst), .s_axis(s_if), .m_axis(m_if),
        .stat_beats(stat_beats), .stat_last_beats(stat_last_beats),
        .stat_config_beats(stat_config_beats), .stat_packets(stat_packets),
        .err_valid_drop(err_valid_drop), .err_beat_ovf(err_beat_ovf),
        .dbg_state(dbg_state)
    );

    axis_conv_in_slice #(.BEATS_WIDTH(3), .PACKETS_WIDTH(16)) dut_narrow (
        .aclk(clk), .areset(rst), .s_axis(s2_if), .m_axis(m2_if),
        .stat_beats(stat_beats2), .stat_last_beats(stat_last_beats2),
        .stat_config_beats(stat_config_beats2), .stat_packets(stat_packets2),
        .err_valid_drop(err_valid_drop2), .err_beat_ovf(err_beat_ovf2),
        .dbg_state(dbg_state2)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];
    int  acc_cnt = 0;
    int  out_cnt = 0;
    bit  chk_en  = 1'b0;
    logic [3:0] rdy_pat = 4'b0000;
    int  rdy_idx = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Downstream ready follows a 4-cycle repeating pattern.
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = rdy_pat[rdy_idx];
            rdy_idx     = (rdy_idx + 1) % 4;
        end
    end

    // Monitor: occupancy model, then input/output handshake bookkeeping.
    initial begin
        int occ;
        skid_state_e exp_st;
        logic [W-1:0] got, exp;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                occ    = acc_cnt - out_cnt;
                exp_st = (occ <= 0) ? ST_EMPTY : (occ == 1) ? ST_ONE : ST_FULL;
                chk("state", 64'(dbg_state), 64'(exp_st));
                chk("s_ready", 64'(s_if.tready), 64'(occ < 2));
                chk("m_valid", 64'(m_if.tvalid), 64'(occ > 0));
                if (s_if.tvalid && s_if.tready) begin
                    exp_q.push_back({s_if.tlast, s_if.tuser, s_if.pixels_tdata, s_if.weights_tdata});
                    acc_cnt++;
                end
                if (m_if.tvalid && m_if.tready) begin
                    out_cnt++;
                    got = {m_if.tlast, m_if.tuser, m_if.pixels_tdata, m_if.weights_tdata};
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL out_beat: got %0h expected none (queue empty)", got);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got === exp) n_pass++;
                        else $display("FAIL out_beat: got %0h expected %0h", got, exp);
                    end
                end
            end
        end
    end

    // Presents one beat and holds it until accepted; ends at posedge+1.
    task automatic send_beat(input int pkt, input int k, input bit last, input bit cfg);
        logic [31:0] pw, ww;
        logic [15:0] tu;
        bit done;
        pw = 32'(pkt * 1000 + k) ^ 32'h5A5A_0000;
        ww = 32'(k * 7919 + pkt * 13) ^ 32'hC3C3_C3C3;
        tu = 16'(pkt * 256 + k);
        tu[I_IS_CONFIG] = cfg;
        s_if.tvalid        = 1'b1;
        s_if.tlast         = last;
        s_if.tuser         = tu;
        s_if.pixels_tdata  = {(PIXELS_WIDTH/32){pw}};
        s_if.weights_tdata = {(WEIGHTS_WIDTH/32){ww}};
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            done = s_if.tready;
            step();
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_packet(input int pkt, input int n, input logic [15:0] cfg_mask);
        for (int k = 1; k <= n; k++) send_beat(pkt, k, k == n, cfg_mask[k-1]);
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !m_if.tvalid;
        end
        if (!done) chk(name, 64'd0, 64'd1);
        step();
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        acc_cnt = 0;
        out_cnt = 0;
    endtask

    typedef struct {
        int          n_beats;
        logic [15:0] cfg_mask;
        logic [3:0]  rdy;
        int          exp_last;
        int          exp_cfg;
        int          exp_pkts;
    } pkt_vec_t;

    pkt_vec_t vecs[4];

    initial begin
        vecs[0] = '{n_beats: 10, cfg_mask: 16'h0000, rdy: 4'b1111, exp_last: 10, exp_cfg: 0, exp_pkts: 1};
        vecs[1] = '{n_beats: 10, cfg_mask: 16'h0000, rdy: 4'b1001, exp_last: 10, exp_cfg: 0, exp_pkts: 2};
        vecs[2] = '{n_beats: 5,  cfg_mask: 16'h0003, rdy: 4'b1111, exp_last: 5,  exp_cfg: 2, exp_pkts: 3};
        vecs[3] = '{n_beats: 3,  cfg_mask: 16'h0007, rdy: 4'b0101, exp_last: 3,  exp_cfg: 3, exp_pkts: 4};

        s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = '0;
        s_if.pixels_tdata = '0; s_if.weights_tdata = '0;

        // Power-up reset
        do_reset();
        @(negedge clk);
        chk("rst_s_ready", 64'(s_if.tready), 64'd0);
        chk("rst_m_valid", 64'(m_if.tvalid), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(ST_EMPTY));
        chk("rst_beats", 64'(stat_beats), 64'd0);
        chk("rst_packets", 64'(stat_packets), 64'd0);
        chk("rst_errs", 64'({err_valid_drop, err_beat_ovf}), 64'd0);
        step();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready_rise", 64'(s_if.tready), 64'd1);
        step();

        // Table-driven packets
        foreach (vecs[i]) begin
            rdy_pat = vecs[i].rdy;
            send_packet(i + 1, vecs[i].n_beats, vecs[i].cfg_mask);
            wait_drain("drain_timeout");
            @(negedge clk);
            chk("pkt_last_beats", 64'(stat_last_beats), 64'(vecs[i].exp_last));
            chk("pkt_config_beats", 64'(stat_config_beats), 64'(vecs[i].exp_cfg));
            chk("pkt_packets", 64'(stat_packets), 64'(vecs[i].exp_pkts));
            chk("pkt_beats_zero", 64'(stat_beats), 64'd0);
            chk("pkt_no_ovf", 64'(err_beat_ovf), 64'd0);
            step();
        end

        // Valid withdrawn while the slice is full
        rdy_pat = 4'b0000;
        step();
        send_beat(5, 1, 1'b0, 1'b0);
        send_beat(5, 2, 1'b1, 1'b0);
        s_if.tuser = 16'h0BAD;
        step();
        step();
        @(negedge clk);
        chk("drop_before", 64'(err_valid_drop), 64'd0);
        chk("full_ready_low", 64'(s_if.tready), 64'd0);
        step();
        s_if.tvalid = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("drop_set", 64'(err_valid_drop), 64'd1);
        step();
        rdy_pat = 4'b1111;
        wait_drain("drain_timeout");
        @(negedge clk);
        chk("drop_pkt_last", 64'(stat_last_beats), 64'd2);
        chk("drop_pkt_packets", 64'(stat_packets), 64'd5);
        step();
        send_packet(7, 4, 16'h0000);
        wait_drain("drain_timeout");
        @(negedge clk);
        chk("after_drop_last", 64'(stat_last_beats), 64'd4);
        chk("after_drop_packets", 64'(stat_packets), 64'd6);
        chk("drop_sticky", 64'(err_valid_drop), 64'd1);
        step();

        // Reset with two beats buffered mid-packet
        rdy_pat = 4'b0000;
        step();
        send_beat(8, 1, 1'b0, 1'b0);
        send_beat(8, 2, 1'b0, 1'b0);
        s_if.tvalid = 1'b0;
        @(negedge clk);
        chk("pre_rst_full", 64'(dbg_state), 64'(ST_FULL));
        chk_en = 1'b0;
        do_reset();
        @(negedge clk);
        chk("mid_rst_m_valid", 64'(m_if.tvalid), 64'd0);
        chk("mid_rst_s_ready", 64'(s_if.tready), 64'd0);
        chk("mid_rst_stats", 64'({stat_beats, stat_last_beats, stat_config_beats}), 64'd0);
        chk("mid_rst_packets", 64'(stat_packets), 64'd0);
        chk("mid_rst_errs", 64'({err_valid_drop, err_beat_ovf}), 64'd0);
        chk("mid_rst_narrow", 64'({stat_packets2, err_beat_ovf2, err_valid_drop2}), 64'd0);
        step();
        chk_en = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready_rise", 64'(s_if.tready), 64'd1);
        step();

        // Beat-counter saturation on the 3-bit instance
        rdy_pat = 4'b1111;
        for (int k = 1; k <= 8; k++) send_beat(9, k, 1'b0, 1'b0);
        s_if.tvalid = 1'b0;
        wait_drain("drain_timeout");
        @(negedge clk);
        chk("sat_beats", 64'(stat_beats2), 64'd7);
        chk("sat_ovf", 64'(err_beat_ovf2), 64'd1);
        chk("wide_beats", 64'(stat_beats), 64'd8);
        step();
        send_beat(9, 9, 1'b1, 1'b0);
        s_if.tvalid = 1'b0;
        wait_drain("drain_timeout");
        @(negedge clk);
        chk("sat_last_beats", 64'(stat_last_beats2), 64'd7);
        chk("sat_beats_clear", 64'(stat_beats2), 64'd0);
        chk("sat_packets", 64'(stat_packets2), 64'd1);
        chk("wide_last_beats", 64'(stat_last_beats), 64'd9);
        chk("wide_no_ovf", 64'(err_beat_ovf), 64'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_conv_in_slice.md
Name: axis_conv_in_slice

Overview:
- Registered AXI-Stream slice between the input pipe (synchronised pixels + weights + conv tuser) and the conv engine.
- Breaks the combinational ready/valid path: m_axis_tready of the input pipe feeds weights/pixels ready logic, and the conv engine's ready is deep.
- Full-throughput 2-entry skid buffer; 1-cycle latency.
- Per-packet beat and packet counters plus sticky protocol-error flags for bring-up debug.

Parameters:
UNITS, 8, pixel lanes per copy
COPIES, 2, pixel stream copies (1 or 2)
CORES, 4, conv cores
MEMBERS, 8, weights per core per beat
WORD_WIDTH, 8, bits per pixel/weight word
TUSER_WIDTH_CONV_IN, 16, conv-engine tuser width
I_IS_CONFIG, 6, tuser bit index marking a config beat
BEATS_WIDTH, 20, width of beat counters
PACKETS_WIDTH, 16, width of packet counter

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
s_axis_tready  out  1  upstream ready (registered)
s_axis_tvalid  in  1  upstream valid
s_axis_tlast  in  1  end of packet (last weight beat)
s_axis_tuser  in  TUSER_WIDTH_CONV_IN  conv tuser
s_axis_pixels_tdata  in  COPIES*WORD_WIDTH*UNITS  pixel data
s_axis_weights_tdata  in  WORD_WIDTH*CORES*MEMBERS  weight data
m_axis_tready  in  1  conv engine ready
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  end of packet
m_axis_tuser  out  TUSER_WIDTH_CONV_IN  conv tuser
m_axis_pixels_tdata  out  COPIES*WORD_WIDTH*UNITS  pixel data
m_axis_weights_tdata  out  WORD_WIDTH*CORES*MEMBERS  weight data
stat_beats  out  BEATS_WIDTH  beats output in current packet
stat_last_beats  out  BEATS_WIDTH  total beats of last completed packet
stat_config_beats  out  BEATS_WIDTH  config beats in last completed packet
stat_packets  out  PACKETS_WIDTH  completed packets (wraps)
err_valid_drop  out  1  sticky: s_axis_tvalid deasserted before acceptance
err_beat_ovf  out  1  sticky: beat counter saturated

Behaviour:
- Reset (areset high at posedge): m_axis_tvalid=0, s_axis_tready=0, skid empty, all stat_* = 0, err_* = 0; tdata/tuser/tlast regs don't-care (bench must not check them while m_axis_tvalid=0). s_axis_tready rises the first cycle after areset is low.
- Payload = {tlast, tuser, pixels, weights}, carried as one vector. Main reg M and skid reg S.
- States: EMPTY (M invalid), ONE (M valid, S invalid), FULL (both valid).
- EMPTY: s_axis_tready=1; s handshake -> load M, go ONE.
- ONE: s_axis_tready=1. Input hs with output hs -> M reloads, stay ONE. Input hs only -> store to S, go FULL. Output hs only -> EMPTY.
- FULL: s_axis_tready=0. Output hs -> M<=S, go ONE. No input is accepted.
- s_axis_tready is a flop: 1 in EMPTY/ONE, 0 in FULL; never combinationally dependent on m_axis_tready.
- Latency: a beat accepted at cycle n is valid at m on cycle n+1 when the slice is empty. Sustained throughput is 1 beat/cycle with m_axis_tready held high. Order is preserved; no beat is dropped or duplicated.
- Counters advance on the output handshake (m_axis_tvalid && m_axis_tready) only.
- Each handshake: stat_beats +1, saturating at all-ones. Reaching saturation sets err_beat_ovf.
- Handshake with tuser[I_IS_CONFIG]=1: internal config counter +1 (saturating).
- Handshake with tlast=1: stat_last_beats <= stat_beats+1 (saturating); stat_config_beats <= cfg count including this beat; stat_beats <= 0; cfg count <= 0; stat_packets +1 (wraps).
- err_valid_drop: set when s_axis_tvalid was 1 and s_axis_tready was 0 in cycle n-1, and s_axis_tvalid=0 in cycle n. It is sticky until areset.
- Reset mid-packet: all contents are discarded and counters cleared. An in-flight upstream beat is lost; upstream is also reset.
- COPIES=1: the pixel width shrinks accordingly and there is no other behaviour change.

Decomposition:
- Shared params header: UNITS, COPIES, CORES, MEMBERS, WORD_WIDTH, TUSER_WIDTH_CONV_IN, I_IS_CONFIG, plus derived widths PIXELS_WIDTH = COPIES*WORD_WIDTH*UNITS and WEIGHTS_WIDTH = WORD_WIDTH*CORES*MEMBERS. These are added beside the existing conv tuser indices.
- One natural sub-module: axis_skid_reg (generic width W, 2-entry skid, same handshake rules). The slice wraps it with the counter/error logic.

Test Plan:
- Stream 10 beats, tlast on beat 10, m_axis_tready=1: first output 1 cycle after first accept, 10 consecutive outputs, identical data. Then stat_last_beats=10, stat_packets=1, stat_beats=0.
- Same stream with m_axis_tready = 1,0,0,1 repeating: s_axis_tready drops exactly one cycle after the slice fills. No loss or duplication; output order 1..10.
- Packet of 5 beats with tuser[6]=1 on beats 1–2: stat_config_beats=2, stat_last_beats=5.
- Hold s_axis_tvalid=1 while full, then drop it for one cycle before acceptance: err_valid_drop=1 and it remains 1; a subsequent normal packet passes unaffected.
- Assert areset for 1 cycle mid-packet with 2 beats buffered: next cycle m_axis_tvalid=0, s_axis_tready=0, all stat_* = 0, err_* = 0; the cycle after that, s_axis_tready=1.
- BEATS_WIDTH=3, 9-beat packet: stat_beats saturates at 7, err_beat_ovf=1, stat_last_beats=7.
